// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine
//   DIM x DIM signed integer matrix multiply, C = A*B or C = C + A*B, using a
//   single time-multiplexed registered MAC. Operands stream in (A row-major,
//   then B row-major) over a valid/ready port; C streams out row-major over a
//   valid/ready port. C persists between operations until reset or a
//   non-accumulate run replaces it.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, accumulate   begin operation (sampled in IDLE), accumulate mode
//   in_valid/in_ready   operand handshake, in_data = DATA_W operand word
//   out_valid/out_ready result handshake, out_data = ACC_W C element
//   out_last            marks C[DIM-1][DIM-1]
//   busy                engine not idle
//   done                one-cycle pulse after the final result handshake
module matrix_mac_engine #(
  parameter int DIM    = 2,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2*DATA_W + $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              accumulate,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int N2 = DIM*DIM;
  localparam int IW = $clog2(DIM);
  localparam int AW = $clog2(N2);
  localparam int LW = $clog2(2*N2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  state_t state, state_d;

  logic signed [DATA_W-1:0] a_mem [N2];
  logic signed [DATA_W-1:0] b_mem [N2];
  logic signed [ACC_W-1:0]  c_mem [N2];

  logic          acc_mode;
  logic [LW-1:0] load_cnt;
  logic [IW-1:0] ci, cj, ck;
  logic [AW-1:0] drain_idx;
  logic          done_q;

  logic          in_fire, load_last, mac_last, drain_last, out_fire;
  logic [AW-1:0] a_idx, b_idx, c_idx;

  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic signed [ACC_W-1:0]    base, mac_sum;

  assign in_fire    = (state == S_LOAD) && in_valid;
  assign out_fire   = (state == S_DRAIN) && out_ready;
  assign load_last  = (load_cnt == LW'(2*N2-1));
  assign drain_last = (drain_idx == AW'(N2-1));
  assign mac_last   = (ci == IW'(DIM-1)) && (cj == IW'(DIM-1)) && (ck == IW'(DIM-1));
  assign busy       = (state != S_IDLE);
  assign done       = done_q;

  // MAC datapath: loop order i (ci) outer, j (cj) middle, k (ck) inner
  always_comb begin
    a_idx = AW'(int'(ci)*DIM + int'(ck));
    b_idx = AW'(int'(ck)*DIM + int'(cj));
    c_idx = AW'(int'(ci)*DIM + int'(cj));
    // operands widened first so the product keeps all 2*DATA_W bits
    a_ext   = (2*DATA_W)'(a_mem[a_idx]);
    b_ext   = (2*DATA_W)'(b_mem[b_idx]);
    prod    = a_ext * b_ext;
    base    = (ck == '0 && !acc_mode) ? '0 : c_mem[c_idx];
    mac_sum = base + ACC_W'(prod);
  end

  // next-state and outputs
  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && load_last) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (mac_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = c_mem[drain_idx];
        out_last  = drain_last;
        if (out_ready && drain_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // operand storage needs no reset: every run reloads all words
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (load_cnt < LW'(N2)) a_mem[load_cnt[AW-1:0]] <= in_data;
      else                    b_mem[AW'(load_cnt - LW'(N2))] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_mode  <= 1'b0;
      load_cnt  <= '0;
      ci        <= '0;
      cj        <= '0;
      ck        <= '0;
      drain_idx <= '0;
      done_q    <= 1'b0;
      c_mem     <= '{default: '0};
    end else begin
      done_q <= out_fire && drain_last;

      if (state == S_IDLE && start) begin
        acc_mode <= accumulate;
        load_cnt <= '0;
      end

      if (in_fire) begin
        load_cnt <= load_cnt + 1'b1;
        if (load_last) begin
          ci <= '0;
          cj <= '0;
          ck <= '0;
        end
      end

      if (state == S_COMPUTE) begin
        c_mem[c_idx] <= mac_sum;
        if (ck == IW'(DIM-1)) begin
          ck <= '0;
          if (cj == IW'(DIM-1)) begin
            cj <= '0;
            ci <= ci + 1'b1;
          end else begin
            cj <= cj + 1'b1;
          end
        end else begin
          ck <= ck + 1'b1;
        end
        if (mac_last) drain_idx <= '0;
      end

      if (out_fire) drain_idx <= drain_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_mac_engine.sv
module tb_matrix_mac_engine;

  localparam int DIM    = 2;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 2*DATA_W + $clog2(DIM);
  localparam int N2     = DIM*DIM;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              accumulate;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  matrix_mac_engine #(
    .DIM   (DIM),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .accumulate(accumulate),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int opA [N2];
  int opB [N2];
  logic signed [ACC_W-1:0] model_c [N2];

  task automatic check_eq(input string tag, input logic [ACC_W-1:0] got,
                          input logic [ACC_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: textbook matrix product in ACC_W-bit signed arithmetic
  task automatic model_run(input bit acc);
    logic signed [ACC_W-1:0] s;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        s = acc ? model_c[i*DIM+j] : '0;
        for (int k = 0; k < DIM; k++)
          s = s + ACC_W'(opA[i*DIM+k]) * ACC_W'(opB[k*DIM+j]);
        model_c[i*DIM+j] = s;
      end
    end
  endtask

  task automatic load_ops(input bit acc, input bit gaps);
    int w = 0;
    int guard = 0;
    start = 1'b1;
    accumulate = acc;
    tick();
    start = 1'b0;
    accumulate = 1'b0;
    check_eq("busy_after_start", busy, 1);
    while (w < 2*N2 && guard < 500) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (w < N2) ? opA[w] : opB[w-N2];
      if (in_valid) check_eq("in_ready_load", in_ready, 1);
      tick();
      if (in_valid) w++;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    check_eq("load_words", w, 2*N2);
  endtask

  task automatic run_op(input bit acc, input bit gaps, input int stall_mode,
                        input bit poke_start);
    int n = 0;
    load_ops(acc, gaps);
    model_run(acc);
    check_eq("in_ready_compute", in_ready, 0);
    while (!out_valid && n < 100) begin
      start    = poke_start && (n == 2);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      tick();
      n++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check_eq("latency", n, DIM*DIM*DIM);
    for (int e = 0; e < N2; e++) begin
      int stalls;
      stalls = (stall_mode == 1) ? 3 : (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      out_ready = 1'b0;
      for (int s = 0; s < stalls; s++) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, model_c[e]);
        check_eq("stall_last", out_last, e == N2-1);
        tick();
      end
      out_ready = 1'b1;
      check_eq("out_valid", out_valid, 1);
      check_eq("out_data", out_data, model_c[e]);
      check_eq("out_last", out_last, e == N2-1);
      tick();
      out_ready = 1'b0;
    end
    check_eq("done_pulse", done, 1);
    check_eq("valid_drop", out_valid, 0);
    check_eq("busy_end", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    accumulate = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N2; i++) model_c[i] = '0;

    tick();
    tick();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    tick();

    // stray operand words in IDLE are refused
    in_valid = 1'b1;
    in_data  = 32'd123;
    for (int c = 0; c < 3; c++) begin
      check_eq("idle_in_ready", in_ready, 0);
      tick();
      check_eq("idle_busy", busy, 0);
    end
    in_valid = 1'b0;

    opA = '{1, 2, 3, 4};
    opB = '{5, 6, 7, 8};
    run_op(0, 0, 0, 0);
    tick();
    check_eq("done_one_cycle", done, 0);

    // accumulate with stalls and a start poke, then back-to-back rerun
    // whose start coincides with the done pulse
    run_op(1, 1, 1, 1);
    run_op(0, 1, 2, 0);
    tick();
    check_eq("no_second_run", busy, 0);
    check_eq("done_low", done, 0);

    opA = '{-1, 0, 0, -1};
    run_op(0, 0, 1, 0);

    // reset in the middle of COMPUTE clears C
    opA = '{1, 2, 3, 4};
    load_ops(0, 1);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_data", out_data, '0);
    rst_n = 1'b1;
    for (int i = 0; i < N2; i++) model_c[i] = '0;
    tick();
    run_op(1, 0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      bit wide;
      wide = 1'($urandom_range(0, 1));
      for (int i = 0; i < N2; i++) begin
        opA[i] = wide ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
        opB[i] = wide ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
      end
      run_op(1'($urandom_range(0, 1)), 1, 2, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
